bt656_in: RTL and testbench
===========================

BT656_IN -- requirements
Module: bt656_in

Interface
REQ-001 SHALL provide parameter WDOG_LEN, default 2048, meaning the number of cycles without a valid timing reference (TRS) before lock is lost.
REQ-002 SHALL provide ports:
- CLK_i  in  1  byte clock
- RST  in  1  reset, asynchronous, active-high
- EN_i  in  1  decoder enable
- DIN_i  in  8  BT.656 byte stream
- PIX_o  out  8  registered copy of DIN_i
- PIX_VD_o  out  1  PIX_o is an active-video byte
- F_o  out  1  field bit of last accepted TRS
- V_o  out  1  vertical blanking bit of last accepted TRS
- H_o  out  1  H bit of last accepted TRS
- LINE_START_o  out  1  pulse on accepted SAV with V=0
- FIELD_START_o  out  1  pulse on first active SAV of a field
- FRAME_START_o  out  1  FIELD_START_o with F=0
- PIX_CNT_o  out  11  active byte index in line
- LINE_CNT_o  out  10  active line index in field
- SYNC_ERR_o  out  1  pulse on rejected TRS
- LOCKED_o  out  1  decoder locked

Function
REQ-003 SHALL parse TRS with FSM states S_SCAN, S_FF, S_Z1, S_Z2: S_SCAN->S_FF on 0xFF; S_FF->S_Z1 on 0x00, else S_SCAN; S_Z1->S_Z2 on 0x00, else S_SCAN; S_Z2 evaluates the XY byte and returns to S_SCAN; 0xFF in S_Z1/S_Z2 goes to S_FF.
REQ-004 SHALL accept XY only if bit7=1 and P3=V^H, P2=F^H, P1=F^V, P0=F^V^H; an accepted XY SHALL update F_o/V_o/H_o one cycle after the XY byte.
REQ-005 A 0x00,0x00 sequence not preceded by 0xFF, or an XY failing REQ-004, SHALL pulse SYNC_ERR_o one cycle and leave F_o/V_o/H_o unchanged.
REQ-006 PIX_o SHALL equal DIN_i delayed one cycle at all times.
REQ-007 An internal active flag SHALL set on an accepted XY with H=0, V=0 and clear on any 0xFF input, on an accepted XY with H=1, or on an accepted XY with V=1.
REQ-008 PIX_VD_o SHALL be 1 for byte b iff the active flag is set when b arrives and b != 0xFF; no XY byte SHALL be flagged valid.
REQ-009 PIX_CNT_o SHALL clear to 0 on accepted SAV, increment after each valid byte, and saturate at 2047.
REQ-010 LINE_CNT_o SHALL clear to 0 on an accepted XY with V=1, increment on each LINE_START_o except the first of a field, and saturate at 1023.
REQ-011 FIELD_START_o SHALL pulse on the first LINE_START_o after any accepted XY with V=1; FRAME_START_o SHALL pulse simultaneously when F=0.
REQ-012 LOCKED_o SHALL set on an accepted XY, and SHALL clear on SYNC_ERR_o or after WDOG_LEN cycles without an accepted XY; clearing SHALL also clear the active flag.
REQ-013 With EN_i=0, the FSM SHALL hold S_SCAN, PIX_VD_o and all pulses SHALL be 0, LOCKED_o SHALL clear, and counters SHALL hold.
REQ-014 Simultaneous watchdog expiry and accepted XY SHALL resolve to locked.

Reset
REQ-015 On RST, all outputs SHALL be 0, the FSM SHALL be S_SCAN, and the watchdog and counters SHALL be 0; RST mid-line SHALL discard the partial TRS.

Configuration
REQ-016 With macro BT656_IN_ECC_EN defined, an XY byte whose F/V/H/P3..P0 contain a single-bit error SHALL be corrected using the BT.656 syndrome table and accepted without SYNC_ERR_o; double errors SHALL be rejected per REQ-005.
REQ-017 Without BT656_IN_ECC_EN, any protection mismatch SHALL be rejected per REQ-005.

Verification
REQ-018 Stream FF 00 00 80 then 1440 bytes 0x10/0x80, then FF 00 00 9D -> LINE_START_o=1 once, 1440 PIX_VD_o cycles, final PIX_CNT_o=1440, H_o=1 after EAV.
REQ-019 Full 625-line PAL frame from the paired BT.656 encoder -> FRAME_START_o once, FIELD_START_o twice, LINE_CNT_o peaks at 287 per field, no SYNC_ERR_o.
REQ-020 XY=0x81 (P0 flipped) -> with ECC, accepted as 0x80, no error; without ECC, SYNC_ERR_o pulse, F/V/H unchanged.
REQ-021 XY=0x83 (two bits flipped) -> SYNC_ERR_o pulse, LOCKED_o=0 next cycle in both builds.
REQ-022 Stream stops with constant 0x10 for WDOG_LEN cycles after lock -> LOCKED_o falls exactly at WDOG_LEN cycles.
REQ-023 Assert RST between the 00 and 00 bytes of a SAV -> outputs 0, that SAV ignored, next full SAV accepted.

Source files
------------

// File: rtl/bt656_in.sv
// ---------------------------------------------------------------------------
// bt656_in
//
// BT.656 byte-stream input decoder. Finds timing reference codes
// (FF 00 00 XY), checks the XY protection bits, tracks the F/V/H flags,
// marks active-video bytes and keeps pixel/line counters. A watchdog drops
// lock when no valid TRS has been seen for WDOG_LEN cycles.
//
// Build option:
//   BT656_IN_ECC_EN - when defined, a single-bit error in the F/V/H/P3..P0
//                     bits of an XY byte is corrected and the code accepted.
//                     Double errors are still rejected.
//
// Parameters:
//   WDOG_LEN       cycles without an accepted XY before lock is lost
//
// Ports:
//   CLK_i          byte clock
//   RST            asynchronous reset, active-high
//   EN_i           decoder enable
//   DIN_i[7:0]     BT.656 byte stream
//   PIX_o[7:0]     DIN_i delayed one cycle
//   PIX_VD_o       PIX_o is an active-video byte
//   F_o/V_o/H_o    flags of the last accepted TRS
//   LINE_START_o   pulse on accepted SAV with V=0
//   FIELD_START_o  pulse on first active SAV of a field
//   FRAME_START_o  FIELD_START_o with F=0
//   PIX_CNT_o      active byte index in line (saturates at 2047)
//   LINE_CNT_o     active line index in field (saturates at 1023)
//   SYNC_ERR_o     pulse on a rejected TRS
//   LOCKED_o       decoder locked
//
// All outputs are registered and change one cycle after the byte that
// caused them. The internal 'state' register is the TRS parser state.
// ---------------------------------------------------------------------------
`default_nettype none

module bt656_in #(
    parameter int WDOG_LEN = 2048
) (
    input  logic        CLK_i,
    input  logic        RST,
    input  logic        EN_i,
    input  logic [7:0]  DIN_i,
    output logic [7:0]  PIX_o,
    output logic        PIX_VD_o,
    output logic        F_o,
    output logic        V_o,
    output logic        H_o,
    output logic        LINE_START_o,
    output logic        FIELD_START_o,
    output logic        FRAME_START_o,
    output logic [10:0] PIX_CNT_o,
    output logic [9:0]  LINE_CNT_o,
    output logic        SYNC_ERR_o,
    output logic        LOCKED_o
);

    localparam int WDOG_W = (WDOG_LEN > 1) ? $clog2(WDOG_LEN + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LEN - 1);

    typedef enum logic [1:0] {
        S_SCAN = 2'd0,
        S_FF   = 2'd1,
        S_Z1   = 2'd2,
        S_Z2   = 2'd3
    } state_t;

    state_t            state;
    logic              prev_zero;   // previous enabled byte was 0x00
    logic              active;      // inside an active-video line
    logic              field_pend;  // V=1 seen, next line start opens a field
    logic [WDOG_W-1:0] wdog;

    logic              is_ff;
    logic              is_00;
    logic [3:0]        syndrome;
    logic [2:0]        fvh_fix;     // {F,V,H} after optional correction
    logic              code_ok;
    logic              xy_ok;
    logic              xy_eval;
    logic              xy_accept;
    logic              xy_reject;
    logic              orphan_zero;
    logic              sync_err;
    logic              wdog_expire;
    logic              lock_drop;
    logic              sav;
    logic              v_mark;
    logic              line_start;

    assign is_ff = (DIN_i == 8'hFF);
    assign is_00 = (DIN_i == 8'h00);

    // XY decode. Syndrome bit set means that protection bit disagrees with
    // the F/V/H bits as received.
    always_comb begin
        syndrome = {DIN_i[3] ^ DIN_i[5] ^ DIN_i[4],
                    DIN_i[2] ^ DIN_i[6] ^ DIN_i[4],
                    DIN_i[1] ^ DIN_i[6] ^ DIN_i[5],
                    DIN_i[0] ^ DIN_i[6] ^ DIN_i[5] ^ DIN_i[4]};
        fvh_fix  = DIN_i[6:4];
        code_ok  = 1'b0;
`ifdef BT656_IN_ECC_EN
        // Single errors give odd-weight syndromes: weight 1 is a flipped
        // protection bit, 0111/1011/1101 a flipped F/V/H. Even weight
        // (double error) and 1110 cannot be corrected.
        case (syndrome)
            4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001: code_ok = 1'b1;
            4'b0111: begin
                code_ok    = 1'b1;
                fvh_fix[2] = ~DIN_i[6];
            end
            4'b1011: begin
                code_ok    = 1'b1;
                fvh_fix[1] = ~DIN_i[5];
            end
            4'b1101: begin
                code_ok    = 1'b1;
                fvh_fix[0] = ~DIN_i[4];
            end
            default: code_ok = 1'b0;
        endcase
`else
        code_ok = (syndrome == 4'b0000);
`endif
        xy_ok = DIN_i[7] & code_ok;
    end

    // A 0xFF in the XY slot restarts the TRS rather than being judged.
    assign xy_eval     = EN_i && (state == S_Z2) && !is_ff;
    assign xy_accept   = xy_eval && xy_ok;
    assign xy_reject   = xy_eval && !xy_ok;
    // 00 00 seen while scanning means the FF that should lead it is missing.
    assign orphan_zero = EN_i && (state == S_SCAN) && prev_zero && is_00;
    assign sync_err    = xy_reject || orphan_zero;
    // An accepted XY on the expiry cycle keeps the lock.
    assign wdog_expire = LOCKED_o && (wdog == WDOG_LAST) && !xy_accept;
    assign lock_drop   = sync_err || wdog_expire;

    assign sav        = xy_accept && !fvh_fix[0];
    assign v_mark     = xy_accept && fvh_fix[1];
    assign line_start = xy_accept && !fvh_fix[1] && !fvh_fix[0];

    always_ff @(posedge CLK_i or posedge RST) begin
        if (RST) begin
            state         <= S_SCAN;
            prev_zero     <= 1'b0;
            active        <= 1'b0;
            field_pend    <= 1'b0;
            wdog          <= '0;
            PIX_o         <= 8'h00;
            PIX_VD_o      <= 1'b0;
            F_o           <= 1'b0;
            V_o           <= 1'b0;
            H_o           <= 1'b0;
            LINE_START_o  <= 1'b0;
            FIELD_START_o <= 1'b0;
            FRAME_START_o <= 1'b0;
            PIX_CNT_o     <= 11'd0;
            LINE_CNT_o    <= 10'd0;
            SYNC_ERR_o    <= 1'b0;
            LOCKED_o      <= 1'b0;
        end else begin
            PIX_o <= DIN_i;

            if (!EN_i) begin
                // Disabled: parser idle, lock and active flag lost,
                // counters and F/V/H keep their values.
                state         <= S_SCAN;
                prev_zero     <= 1'b0;
                active        <= 1'b0;
                wdog          <= '0;
                PIX_VD_o      <= 1'b0;
                LINE_START_o  <= 1'b0;
                FIELD_START_o <= 1'b0;
                FRAME_START_o <= 1'b0;
                SYNC_ERR_o    <= 1'b0;
                LOCKED_o      <= 1'b0;
            end else begin
                // TRS parser
                case (state)
                    S_SCAN: if (is_ff) state <= S_FF;
                    // A repeated FF still leads a possible TRS.
                    S_FF: begin
                        if (is_00)      state <= S_Z1;
                        else if (is_ff) state <= S_FF;
                        else            state <= S_SCAN;
                    end
                    S_Z1: begin
                        if (is_00)      state <= S_Z2;
                        else if (is_ff) state <= S_FF;
                        else            state <= S_SCAN;
                    end
                    S_Z2: begin
                        if (is_ff) state <= S_FF;
                        else       state <= S_SCAN;
                    end
                    default: state <= S_SCAN;
                endcase
                prev_zero <= is_00;

                // Valid flag describes the byte being registered into PIX_o.
                PIX_VD_o <= active && !is_ff && (state != S_Z2);

                if (lock_drop || is_ff)
                    active <= 1'b0;
                else if (xy_accept)
                    active <= !fvh_fix[1] && !fvh_fix[0];

                if (xy_accept)
                    {F_o, V_o, H_o} <= fvh_fix;

                if (xy_accept)
                    LOCKED_o <= 1'b1;
                else if (lock_drop)
                    LOCKED_o <= 1'b0;

                if (xy_accept || !LOCKED_o || lock_drop)
                    wdog <= '0;
                else
                    wdog <= wdog + 1'b1;

                SYNC_ERR_o    <= sync_err;
                LINE_START_o  <= line_start;
                FIELD_START_o <= line_start && field_pend;
                FRAME_START_o <= line_start && field_pend && !fvh_fix[2];

                // PIX_CNT_o trails PIX_VD_o by a cycle so that it shows the
                // index of the byte currently in PIX_o, and the byte count
                // once the line has ended.
                if (sav)
                    PIX_CNT_o <= 11'd0;
                else if (PIX_VD_o && (PIX_CNT_o != 11'd2047))
                    PIX_CNT_o <= PIX_CNT_o + 11'd1;

                if (v_mark)
                    field_pend <= 1'b1;
                else if (line_start)
                    field_pend <= 1'b0;

                if (v_mark)
                    LINE_CNT_o <= 10'd0;
                else if (line_start && !field_pend && (LINE_CNT_o != 10'd1023))
                    LINE_CNT_o <= LINE_CNT_o + 10'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bt656_in.sv
`timescale 1ns/1ps

module tb_bt656_in;

  localparam int WDOG = 2048;

  logic        CLK_i = 1'b0;
  logic        RST;
  logic        EN_i;
  logic [7:0]  DIN_i;
  logic [7:0]  PIX_o;
  logic        PIX_VD_o;
  logic        F_o;
  logic        V_o;
  logic        H_o;
  logic        LINE_START_o;
  logic        FIELD_START_o;
  logic        FRAME_START_o;
  logic [10:0] PIX_CNT_o;
  logic [9:0]  LINE_CNT_o;
  logic        SYNC_ERR_o;
  logic        LOCKED_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [7:0] exp_q[$];
  // Legal XY codes indexed by {F,V,H}
  logic [7:0] xy_tab [8];

  // ---------------- clock / reset ----------------
  always #5 CLK_i = ~CLK_i;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  bt656_in #(.WDOG_LEN(WDOG)) dut (
    .CLK_i         (CLK_i),
    .RST           (RST),
    .EN_i          (EN_i),
    .DIN_i         (DIN_i),
    .PIX_o         (PIX_o),
    .PIX_VD_o      (PIX_VD_o),
    .F_o           (F_o),
    .V_o           (V_o),
    .H_o           (H_o),
    .LINE_START_o  (LINE_START_o),
    .FIELD_START_o (FIELD_START_o),
    .FRAME_START_o (FRAME_START_o),
    .PIX_CNT_o     (PIX_CNT_o),
    .LINE_CNT_o    (LINE_CNT_o),
    .SYNC_ERR_o    (SYNC_ERR_o),
    .LOCKED_o      (LOCKED_o)
  );

  // ---------------- driver tasks ----------------
  // Drive one byte, let it be clocked in, return 1ns after the edge.
  task automatic send(input logic [7:0] b);
    DIN_i = b;
    @(posedge CLK_i);
    #1;
  endtask

  task automatic send_trs(input logic [7:0] xy);
    send(8'hFF);
    send(8'h00);
    send(8'h00);
    send(xy);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST   = 1'b1;
    EN_i  = 1'b1;
    DIN_i = 8'hFF;
    repeat (3) @(posedge CLK_i);
    #1;
    vec_cnt++;
    if ({PIX_o, PIX_VD_o, F_o, V_o, H_o, LINE_START_o, FIELD_START_o, FRAME_START_o,
         PIX_CNT_o, LINE_CNT_o, SYNC_ERR_o, LOCKED_o} !== 38'h0) begin
      miss_cnt++;
      $display("FAIL reset_outputs: got pix=%h vd=%b fvh=%b%b%b cnt=%0d line=%0d lock=%b want all 0",
               PIX_o, PIX_VD_o, F_o, V_o, H_o, PIX_CNT_o, LINE_CNT_o, LOCKED_o);
    end
    RST = 1'b0;
    send(8'h10);
    vec_cnt++;
    if (PIX_o !== 8'h10) begin
      miss_cnt++;
      $display("FAIL reset_pix_follow: got %h want 10", PIX_o);
    end
    vec_cnt++;
    if (PIX_VD_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_no_vd: got %b want 0", PIX_VD_o);
    end
  endtask

  task automatic test_line();
    logic [7:0] seq[$];
    logic [7:0] exp_b;
    int vd_n = 0;
    int ls_n = 0;
    seq.push_back(8'hFF); seq.push_back(8'h00); seq.push_back(8'h00); seq.push_back(8'h80);
    for (int i = 0; i < 1440; i++) begin
      exp_b = (i % 2 == 0) ? 8'h80 : 8'h10;
      seq.push_back(exp_b);
      exp_q.push_back(exp_b);
    end
    seq.push_back(8'hFF); seq.push_back(8'h00); seq.push_back(8'h00); seq.push_back(8'h9D);
    foreach (seq[i]) begin
      send(seq[i]);
      if (LINE_START_o) ls_n++;
      if (PIX_VD_o) begin
        vec_cnt++;
        if (PIX_CNT_o !== 11'(vd_n)) begin
          miss_cnt++;
          $display("FAIL line_pix_index: got %0d want %0d", PIX_CNT_o, vd_n);
        end
        vd_n++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miss_cnt++;
          $display("FAIL line_extra_valid: got byte %h want no valid byte", PIX_o);
        end else begin
          exp_b = exp_q.pop_front();
          if (PIX_o !== exp_b) begin
            miss_cnt++;
            $display("FAIL line_pix_data: got %h want %h", PIX_o, exp_b);
          end
        end
      end
    end
    vec_cnt++;
    if (ls_n != 1) begin
      miss_cnt++;
      $display("FAIL line_start_count: got %0d want 1", ls_n);
    end
    vec_cnt++;
    if (vd_n != 1440) begin
      miss_cnt++;
      $display("FAIL line_valid_count: got %0d want 1440", vd_n);
    end
    vec_cnt++;
    if (PIX_CNT_o !== 11'd1440) begin
      miss_cnt++;
      $display("FAIL line_final_cnt: got %0d want 1440", PIX_CNT_o);
    end
    vec_cnt++;
    if (H_o !== 1'b1) begin
      miss_cnt++;
      $display("FAIL line_h_after_eav: got %b want 1", H_o);
    end
    vec_cnt++;
    if (LOCKED_o !== 1'b1) begin
      miss_cnt++;
      $display("FAIL line_locked: got %b want 1", LOCKED_o);
    end
    exp_q.delete();
  endtask

  task automatic test_ecc();
    // P0 flipped SAV
    send_trs(8'h9D);
    send_trs(8'h81);
`ifdef BT656_IN_ECC_EN
    vec_cnt++;
    if ({SYNC_ERR_o, H_o, LOCKED_o, LINE_START_o} !== 4'b0011) begin
      miss_cnt++;
      $display("FAIL ecc_p0_fix: got err,h,lock,ls=%b want 0011",
               {SYNC_ERR_o, H_o, LOCKED_o, LINE_START_o});
    end
`else
    vec_cnt++;
    if ({SYNC_ERR_o, H_o, LOCKED_o, LINE_START_o} !== 4'b1100) begin
      miss_cnt++;
      $display("FAIL ecc_p0_reject: got err,h,lock,ls=%b want 1100",
               {SYNC_ERR_o, H_o, LOCKED_o, LINE_START_o});
    end
`endif
    send(8'h10);
    vec_cnt++;
    if (SYNC_ERR_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL ecc_err_pulse_width: got %b want 0", SYNC_ERR_o);
    end
    // F flipped SAV (0x80 -> 0xC0)
    send_trs(8'h9D);
    send_trs(8'hC0);
`ifdef BT656_IN_ECC_EN
    vec_cnt++;
    if ({SYNC_ERR_o, F_o, H_o, LINE_START_o} !== 4'b0001) begin
      miss_cnt++;
      $display("FAIL ecc_f_fix: got err,f,h,ls=%b want 0001",
               {SYNC_ERR_o, F_o, H_o, LINE_START_o});
    end
`else
    vec_cnt++;
    if ({SYNC_ERR_o, F_o, H_o, LINE_START_o} !== 4'b1010) begin
      miss_cnt++;
      $display("FAIL ecc_f_reject: got err,f,h,ls=%b want 1010",
               {SYNC_ERR_o, F_o, H_o, LINE_START_o});
    end
`endif
    // bit 7 cleared: never acceptable
    send_trs(8'h9D);
    send_trs(8'h1D);
    vec_cnt++;
    if ({SYNC_ERR_o, H_o, LOCKED_o} !== 3'b110) begin
      miss_cnt++;
      $display("FAIL bit7_reject: got err,h,lock=%b want 110", {SYNC_ERR_o, H_o, LOCKED_o});
    end
  endtask

  task automatic test_double_err();
    send_trs(8'h9D);
    vec_cnt++;
    if (LOCKED_o !== 1'b1) begin
      miss_cnt++;
      $display("FAIL double_prelock: got %b want 1", LOCKED_o);
    end
    send_trs(8'h83);
    vec_cnt++;
    if ({SYNC_ERR_o, LOCKED_o, F_o, V_o, H_o} !== 5'b10001) begin
      miss_cnt++;
      $display("FAIL double_reject: got err,lock,f,v,h=%b want 10001",
               {SYNC_ERR_o, LOCKED_o, F_o, V_o, H_o});
    end
  endtask

  task automatic test_orphan_zeros();
    send_trs(8'h9D);
    send(8'h10);
    send(8'h00);
    vec_cnt++;
    if (SYNC_ERR_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL orphan_single_zero: got %b want 0", SYNC_ERR_o);
    end
    send(8'h00);
    vec_cnt++;
    if ({SYNC_ERR_o, LOCKED_o} !== 2'b10) begin
      miss_cnt++;
      $display("FAIL orphan_double_zero: got err,lock=%b want 10", {SYNC_ERR_o, LOCKED_o});
    end
    send(8'h10);
    vec_cnt++;
    if (SYNC_ERR_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL orphan_pulse_width: got %b want 0", SYNC_ERR_o);
    end
  endtask

  task automatic test_enable();
    send_trs(8'h80);
    repeat (5) send(8'h10);
    vec_cnt++;
    if ({PIX_VD_o, LOCKED_o, PIX_CNT_o} !== {2'b11, 11'd4}) begin
      miss_cnt++;
      $display("FAIL en_pre: got vd=%b lock=%b cnt=%0d want 1 1 4", PIX_VD_o, LOCKED_o, PIX_CNT_o);
    end
    EN_i = 1'b0;
    send(8'h10);
    vec_cnt++;
    if ({PIX_o, PIX_VD_o, LOCKED_o, PIX_CNT_o} !== {8'h10, 2'b00, 11'd4}) begin
      miss_cnt++;
      $display("FAIL en_off: got pix=%h vd=%b lock=%b cnt=%0d want 10 0 0 4",
               PIX_o, PIX_VD_o, LOCKED_o, PIX_CNT_o);
    end
    send_trs(8'h9D);
    vec_cnt++;
    if ({PIX_o, H_o, LINE_START_o, SYNC_ERR_o, LOCKED_o} !== {8'h9D, 4'b0000}) begin
      miss_cnt++;
      $display("FAIL en_off_trs: got pix=%h h=%b ls=%b err=%b lock=%b want 9d 0 0 0 0",
               PIX_o, H_o, LINE_START_o, SYNC_ERR_o, LOCKED_o);
    end
    send(8'h00);
    send(8'h00);
    vec_cnt++;
    if (SYNC_ERR_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL en_off_no_err: got %b want 0", SYNC_ERR_o);
    end
    EN_i = 1'b1;
    send(8'h10);
    vec_cnt++;
    if ({PIX_VD_o, LOCKED_o, PIX_CNT_o} !== {2'b00, 11'd4}) begin
      miss_cnt++;
      $display("FAIL en_back_on: got vd=%b lock=%b cnt=%0d want 0 0 4", PIX_VD_o, LOCKED_o, PIX_CNT_o);
    end
  endtask

  task automatic test_watchdog();
    int drop_at = 0;
    int vd_n = 0;
    send_trs(8'h80);
    for (int i = 1; i <= WDOG + 1; i++) begin
      send(8'h10);
      if (PIX_VD_o) vd_n++;
      if (!LOCKED_o && drop_at == 0) drop_at = i;
    end
    vec_cnt++;
    if (drop_at != WDOG) begin
      miss_cnt++;
      $display("FAIL wdog_drop_cycle: got %0d want %0d", drop_at, WDOG);
    end
    vec_cnt++;
    if (vd_n != WDOG) begin
      miss_cnt++;
      $display("FAIL wdog_active_cleared: got %0d valid bytes want %0d", vd_n, WDOG);
    end
    vec_cnt++;
    if (PIX_CNT_o !== 11'd2047) begin
      miss_cnt++;
      $display("FAIL pix_cnt_saturate: got %0d want 2047", PIX_CNT_o);
    end
  endtask

  task automatic test_wdog_vs_accept();
    int drops = 0;
    send_trs(8'h80);
    for (int i = 1; i <= WDOG - 4; i++) begin
      send(8'h10);
      if (!LOCKED_o) drops++;
    end
    send(8'hFF); if (!LOCKED_o) drops++;
    send(8'h00); if (!LOCKED_o) drops++;
    send(8'h00); if (!LOCKED_o) drops++;
    vec_cnt++;
    if (drops != 0) begin
      miss_cnt++;
      $display("FAIL wdog_early_drop: got %0d unlocked cycles want 0", drops);
    end
    send(8'h80);
    vec_cnt++;
    if ({LOCKED_o, LINE_START_o} !== 2'b11) begin
      miss_cnt++;
      $display("FAIL wdog_accept_wins: got lock,ls=%b want 11", {LOCKED_o, LINE_START_o});
    end
    send(8'h10);
    vec_cnt++;
    if (LOCKED_o !== 1'b1) begin
      miss_cnt++;
      $display("FAIL wdog_accept_hold: got %b want 1", LOCKED_o);
    end
  endtask

  task automatic test_reset_mid_trs();
    send_trs(8'hC7);
    vec_cnt++;
    if ({F_o, LOCKED_o} !== 2'b11) begin
      miss_cnt++;
      $display("FAIL rstmid_prelock: got f,lock=%b want 11", {F_o, LOCKED_o});
    end
    send(8'hFF);
    send(8'h00);
    RST = 1'b1;
    #1;
    vec_cnt++;
    if ({PIX_o, PIX_VD_o, F_o, V_o, H_o, LINE_START_o, FIELD_START_o, FRAME_START_o,
         PIX_CNT_o, LINE_CNT_o, SYNC_ERR_o, LOCKED_o} !== 38'h0) begin
      miss_cnt++;
      $display("FAIL rstmid_outputs: got pix=%h f=%b cnt=%0d line=%0d lock=%b want all 0",
               PIX_o, F_o, PIX_CNT_o, LINE_CNT_o, LOCKED_o);
    end
    DIN_i = 8'h10;
    @(posedge CLK_i);
    #1;
    RST = 1'b0;
    send(8'h00);
    vec_cnt++;
    if (SYNC_ERR_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rstmid_no_err: got %b want 0", SYNC_ERR_o);
    end
    send(8'h80);
    vec_cnt++;
    if ({LINE_START_o, LOCKED_o, SYNC_ERR_o} !== 3'b000) begin
      miss_cnt++;
      $display("FAIL rstmid_sav_ignored: got ls,lock,err=%b want 000",
               {LINE_START_o, LOCKED_o, SYNC_ERR_o});
    end
    send_trs(8'h80);
    vec_cnt++;
    if ({LINE_START_o, LOCKED_o} !== 2'b11) begin
      miss_cnt++;
      $display("FAIL rstmid_next_sav: got ls,lock=%b want 11", {LINE_START_o, LOCKED_o});
    end
  endtask

  // 625-line PAL frame with shortened lines (8 video bytes per line).
  task automatic test_pal_frame();
    int frame_n = 0;
    int field_n = 0;
    int line_n  = 0;
    int err_n   = 0;
    int max0    = 0;
    int max1    = 0;
    logic f;
    logic v;
    logic [7:0] b;
    for (int ln = 1; ln <= 625; ln++) begin
      f = (ln >= 313);
      v = (ln <= 22) || (ln >= 311 && ln <= 335) || (ln >= 624);
      for (int k = 0; k < 20; k++) begin
        if (k == 0 || k == 8)           b = 8'hFF;
        else if (k < 3 || (k > 8 && k < 11)) b = 8'h00;
        else if (k == 3)                b = xy_tab[{f, v, 1'b1}];
        else if (k == 11)               b = xy_tab[{f, v, 1'b0}];
        else                            b = (k % 2 == 0) ? 8'h80 : 8'h10;
        send(b);
        if (FRAME_START_o) frame_n++;
        if (FIELD_START_o) field_n++;
        if (LINE_START_o)  line_n++;
        if (SYNC_ERR_o)    err_n++;
        if (F_o) begin
          if (int'(LINE_CNT_o) > max1) max1 = int'(LINE_CNT_o);
        end else begin
          if (int'(LINE_CNT_o) > max0) max0 = int'(LINE_CNT_o);
        end
      end
    end
    vec_cnt++;
    if (frame_n != 1) begin
      miss_cnt++;
      $display("FAIL pal_frame_starts: got %0d want 1", frame_n);
    end
    vec_cnt++;
    if (field_n != 2) begin
      miss_cnt++;
      $display("FAIL pal_field_starts: got %0d want 2", field_n);
    end
    vec_cnt++;
    if (line_n != 576) begin
      miss_cnt++;
      $display("FAIL pal_line_starts: got %0d want 576", line_n);
    end
    vec_cnt++;
    if (max0 != 287) begin
      miss_cnt++;
      $display("FAIL pal_field0_peak: got %0d want 287", max0);
    end
    vec_cnt++;
    if (max1 != 287) begin
      miss_cnt++;
      $display("FAIL pal_field1_peak: got %0d want 287", max1);
    end
    vec_cnt++;
    if (err_n != 0) begin
      miss_cnt++;
      $display("FAIL pal_sync_errors: got %0d want 0", err_n);
    end
    vec_cnt++;
    if (LOCKED_o !== 1'b1) begin
      miss_cnt++;
      $display("FAIL pal_locked: got %b want 1", LOCKED_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    xy_tab = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};
    RST   = 1'b1;
    EN_i  = 1'b1;
    DIN_i = 8'h10;

    test_reset();
    test_line();
    test_ecc();
    test_double_err();
    test_orphan_zeros();
    test_enable();
    test_watchdog();
    test_wdog_vs_accept();
    test_reset_mid_trs();
    test_pal_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
